// File: rtl/immed_decode_stage_pkg.sv
// Shared definitions for the immediate decode stage.
//   imm_type_e : immediate format selected by the extractor
//   Op*        : RV32/RV64 major opcodes (inst[6:0]) used for format decode
package immed_decode_stage_pkg;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5,
    ImmZ    = 3'd6,
    ImmSh   = 3'd7
  } imm_type_e;

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  // Formats whose immediate is sign-extended from inst[31].
  function automatic logic is_signed_fmt(input imm_type_e t);
    return (t == ImmI) || (t == ImmS) || (t == ImmB) || (t == ImmU) || (t == ImmJ);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
//   inst_i     : raw 32-bit instruction word
//   imm_o      : immediate, extended to XLEN
//   imm_type_o : format chosen from the opcode (ImmNone when no immediate)
//   illegal_o  : instruction is not a 32-bit encoding (inst[1:0] != 2'b11)
module imm_extract
  import immed_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;
  logic [31:0] imm32;
  logic        ext_bit;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign illegal_o = (inst_i[1:0] != 2'b11);
  assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    imm_type_o = ImmNone;
    if (!illegal_o) begin
      case (opcode)
        OpLui, OpAuipc:        imm_type_o = ImmU;
        OpJal:                 imm_type_o = ImmJ;
        OpJalr, OpLoad:        imm_type_o = ImmI;
        OpOpImm, OpOpImm32:    imm_type_o = is_shift ? ImmSh : ImmI;
        OpStore:               imm_type_o = ImmS;
        OpBranch:              imm_type_o = ImmB;
        OpSystem:              imm_type_o = funct3[2] ? ImmZ : ImmNone;
        default:               imm_type_o = ImmNone;
      endcase
    end
  end

  // Low 32 bits of every format; the upper XLEN-32 bits are a pure sign fill.
  always_comb begin
    imm32 = '0;
    unique case (imm_type_o)
      ImmI:  imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      ImmS:  imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      ImmB:  imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      ImmU:  imm32 = {inst_i[31:12], 12'h000};
      ImmJ:  imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      ImmZ:  imm32 = {27'h0, inst_i[19:15]};
      ImmSh: begin
        // Only RV64 OP-IMM has a 6-bit shamt; OP-IMM-32 stays 5-bit.
        if ((XLEN == 64) && (opcode == OpOpImm)) begin
          imm32 = {26'h0, inst_i[25:20]};
        end else begin
          imm32 = {27'h0, inst_i[24:20]};
        end
      end
      default: imm32 = '0;
    endcase
  end

  assign ext_bit = is_signed_fmt(imm_type_o) && inst_i[31];

  always_comb begin
    imm_o       = {XLEN{ext_bit}};
    imm_o[31:0] = imm32;
  end

endmodule

// File: rtl/immed_decode_stage.sv
// Immediate decode pipeline stage with valid/ready handshake.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   flush_i               : synchronous kill, drops the held and incoming result
//   valid_i/ready_o       : upstream handshake, inst_i is the instruction word
//   valid_o/ready_i       : downstream handshake on the registered result
//   imm_o/imm_type_o      : registered immediate and its format
//   illegal_o             : registered non-32-bit-encoding flag
//   inst_o                : registered instruction (tied 0 when EXPOSE_INST == 0)
module immed_decode_stage
  import immed_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          EXPOSE_INST = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     inst_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o,
  output logic [31:0]     inst_o
);

  logic [XLEN-1:0] ext_imm;
  imm_type_e       ext_type;
  logic            ext_illegal;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] imm_q;
  imm_type_e       imm_type_q;
  logic            illegal_q;
  logic            accept;

  imm_extract #(
    .XLEN(XLEN)
  ) u_imm_extract (
    .inst_i     (inst_i),
    .imm_o      (ext_imm),
    .imm_type_o (ext_type),
    .illegal_o  (ext_illegal)
  );

  // Output slot is free when empty or being drained this cycle.
  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imm_q      <= '0;
      imm_type_q <= ImmNone;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      imm_q      <= ext_imm;
      imm_type_q <= ext_type;
      illegal_q  <= ext_illegal;
    end
  end

  if (EXPOSE_INST) begin : g_inst
    logic [31:0] inst_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        inst_q <= '0;
      end else if (accept) begin
        inst_q <= inst_i;
      end
    end
    assign inst_o = inst_q;
  end else begin : g_no_inst
    assign inst_o = '0;
  end

  assign valid_o    = valid_q;
  assign imm_o      = imm_q;
  assign imm_type_o = imm_type_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_immed_decode_stage.sv
module tb_immed_decode_stage;
  import immed_decode_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] inst_i;

  logic        ready_o32, valid_o32, ill_o32;
  logic [31:0] imm_o32, inst_o32;
  imm_type_e   type_o32;
  logic        ready_o64, valid_o64, ill_o64;
  logic [63:0] imm_o64;
  logic [31:0] inst_o64;
  imm_type_e   type_o64;

  int checks = 0;
  int failures = 0;

  // Reference state: what the stage should be holding.
  logic        m_valid;
  logic [63:0] m_imm32, m_imm64;
  imm_type_e   m_type32, m_type64;
  logic        m_ill;
  logic [31:0] m_inst;

  immed_decode_stage #(.XLEN(32), .EXPOSE_INST(1'b1)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o32),
    .inst_i(inst_i), .valid_o(valid_o32), .ready_i(ready_i), .imm_o(imm_o32),
    .imm_type_o(type_o32), .illegal_o(ill_o32), .inst_o(inst_o32)
  );

  immed_decode_stage #(.XLEN(64), .EXPOSE_INST(1'b0)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o64),
    .inst_i(inst_i), .valid_o(valid_o64), .ready_i(ready_i), .imm_o(imm_o64),
    .imm_type_o(type_o64), .illegal_o(ill_o64), .inst_o(inst_o64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Immediate value computed arithmetically from the RISC-V field definitions.
  function automatic void ref_decode(input logic [31:0] ins, input bit x64,
                                     output logic [63:0] imm, output imm_type_e ty,
                                     output logic ill);
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    op  = ins[6:0];
    f3  = ins[14:12];
    v   = 0;
    ty  = ImmNone;
    ill = (ins[1:0] != 2'b11);
    if (!ill) begin
      if (op == 7'h37 || op == 7'h17) begin
        ty = ImmU;
        v  = longint'($signed(ins[31:12])) * 4096;
      end else if (op == 7'h6F) begin
        ty = ImmJ;
        v  = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
             + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end else if (op == 7'h67 || op == 7'h03) begin
        ty = ImmI;
        v  = longint'($signed(ins[31:20]));
      end else if (op == 7'h13 || op == 7'h1B) begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ty = ImmSh;
          v  = (op == 7'h13 && x64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin
          ty = ImmI;
          v  = longint'($signed(ins[31:20]));
        end
      end else if (op == 7'h23) begin
        ty = ImmS;
        v  = longint'($signed(ins[31:25])) * 32 + longint'(ins[11:7]);
      end else if (op == 7'h63) begin
        ty = ImmB;
        v  = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
             + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end else if (op == 7'h73 && f3[2]) begin
        ty = ImmZ;
        v  = longint'(ins[19:15]);
      end
    end
    imm = x64 ? 64'(v) : {32'h0, v[31:0]};
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_imm32  = '0;
    m_imm64  = '0;
    m_type32 = ImmNone;
    m_type64 = ImmNone;
    m_ill    = 1'b0;
    m_inst   = '0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid32"}, 64'(valid_o32), 64'(m_valid));
    check_eq({tag, "_valid64"}, 64'(valid_o64), 64'(m_valid));
    check_eq({tag, "_imm32"}, 64'(imm_o32), m_imm32);
    check_eq({tag, "_imm64"}, imm_o64, m_imm64);
    check_eq({tag, "_type32"}, 64'(type_o32), 64'(m_type32));
    check_eq({tag, "_type64"}, 64'(type_o64), 64'(m_type64));
    check_eq({tag, "_ill32"}, 64'(ill_o32), 64'(m_ill));
    check_eq({tag, "_ill64"}, 64'(ill_o64), 64'(m_ill));
    check_eq({tag, "_inst32"}, 64'(inst_o32), 64'(m_inst));
    check_eq({tag, "_inst64"}, 64'(inst_o64), 64'h0);
  endtask

  // One clock: drive, check ready, clock, update reference, check outputs.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    logic exp_ready;
    logic ill64;
    valid_i = v;
    inst_i  = ins;
    ready_i = rdy;
    flush_i = fl;
    #1;
    exp_ready = !m_valid || rdy;
    check_eq({tag, "_ready32"}, 64'(ready_o32), 64'(exp_ready));
    check_eq({tag, "_ready64"}, 64'(ready_o64), 64'(exp_ready));
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_ready) begin
      ref_decode(ins, 1'b0, m_imm32, m_type32, m_ill);
      ref_decode(ins, 1'b1, m_imm64, m_type64, ill64);
      m_inst  = ins;
      m_valid = 1'b1;
    end else if (rdy && m_valid) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  logic [6:0] ops [12];
  logic [31:0] held_imm;

  initial begin
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h73, 7'h33,
            7'h13};
    rst_n   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    inst_i  = '0;
    model_reset();
    #12;
    check_outputs("reset");
    check_eq("reset_ready", 64'(ready_o32), 64'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed known-answer cases.
    step("addi", 1'b1, 32'hFFF00093, 1'b1, 1'b0);
    check_eq("addi_lit", 64'(imm_o32), 64'hFFFFFFFF);
    check_eq("addi_type", 64'(type_o32), 64'(ImmI));
    step("lui", 1'b1, 32'h123450B7, 1'b1, 1'b0);
    check_eq("lui_lit", 64'(imm_o32), 64'h12345000);
    check_eq("lui_type", 64'(type_o32), 64'(ImmU));
    step("lui64", 1'b1, 32'h800000B7, 1'b1, 1'b0);
    check_eq("lui64_lit", imm_o64, 64'hFFFFFFFF80000000);
    step("beq", 1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    check_eq("beq_lit", 64'(imm_o32), 64'hFFFFFFFC);
    check_eq("beq_type", 64'(type_o32), 64'(ImmB));
    step("jal", 1'b1, 32'h0080006F, 1'b1, 1'b0);
    check_eq("jal_lit", 64'(imm_o32), 64'h8);
    check_eq("jal_type", 64'(type_o32), 64'(ImmJ));
    step("csrrwi", 1'b1, 32'h3002D073, 1'b1, 1'b0);
    check_eq("csrrwi_lit", 64'(imm_o32), 64'h5);
    check_eq("csrrwi_type", 64'(type_o32), 64'(ImmZ));
    step("slli64", 1'b1, 32'h03F09093, 1'b1, 1'b0);
    check_eq("slli64_lit", imm_o64, 64'h3F);
    check_eq("slli32_lit", 64'(imm_o32), 64'h1F);

    // Stall: result held while downstream is not ready.
    step("hold", 1'b1, 32'hFFF00093, 1'b0, 1'b0);
    held_imm = imm_o32;
    for (int i = 0; i < 5; i++) begin
      step("stall", 1'b1, 32'h123450B7, 1'b0, 1'b0);
      check_eq("stall_ready", 64'(ready_o32), 64'h0);
      check_eq("stall_imm", 64'(imm_o32), 64'(held_imm));
    end
    step("release", 1'b1, 32'h123450B7, 1'b1, 1'b0);
    check_eq("release_lit", 64'(imm_o32), 64'h12345000);

    // Flush coincident with a valid input.
    step("flush", 1'b1, 32'hFE000EE3, 1'b1, 1'b1);
    check_eq("flush_valid", 64'(valid_o32), 64'h0);
    step("illegal", 1'b1, 32'h00000001, 1'b1, 1'b0);
    check_eq("illegal_flag", 64'(ill_o32), 64'h1);
    check_eq("illegal_imm", 64'(imm_o32), 64'h0);
    check_eq("illegal_type", 64'(type_o32), 64'(ImmNone));

    // Reset in the middle of a stall.
    step("prestall", 1'b1, 32'h0080006F, 1'b0, 1'b0);
    valid_i = 1'b1;
    inst_i  = 32'hFFF00093;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check_eq("midrst_ready", 64'(ready_o32), 64'h1);
    #2;
    rst_n = 1'b1;
    step("postrst", 1'b1, 32'hFFF00093, 1'b0, 1'b0);
    check_eq("postrst_valid", 64'(valid_o32), 64'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
      step("rand", 1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/immed_decode_stage.md
IMMED_DECODE_STAGE -- requirements
Module: immed_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter EXPOSE_INST, default 1, registering and driving inst_o when 1; when 0, inst_o is tied to 0.
REQ-003 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, synchronous pipeline kill.
REQ-006 SHALL have port valid_i, input, 1, upstream instruction valid.
REQ-007 SHALL have port ready_o, output, 1, stage can accept.
REQ-008 SHALL have port inst_i, input, 32, raw instruction word.
REQ-009 SHALL have port valid_o, output, 1, registered result valid.
REQ-010 SHALL have port ready_i, input, 1, downstream accept.
REQ-011 SHALL have port imm_o, output, XLEN, selected immediate.
REQ-012 SHALL have port imm_type_o, output, imm_type_e, immediate format selected.
REQ-013 SHALL have port illegal_o, output, 1, set when inst[1:0] != 2'b11 (non-32-bit encoding).
REQ-014 SHALL have port inst_o, output, 32, registered instruction.

Function
REQ-015 SHALL decode the format from opcode inst[6:0]: LUI 0110111 and AUIPC 0010111 -> U; JAL 1101111 -> J; JALR 1100111, LOAD 0000011, OP-IMM 0010011 and OP-IMM-32 0011011 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; SYSTEM 1110011 with funct3[2]=1 -> Z; all others -> NONE.
REQ-016 SHALL override I to SH for OP-IMM or OP-IMM-32 when funct3 is 001 or 101.
REQ-017 SHALL sign-extend I, S, B, U and J immediates from inst[31] to XLEN, using the standard RISC-V bit scatter; B and J have bit 0 = 0; U has bits [11:0] = 0.
REQ-018 SHALL form Z as inst[19:15] zero-extended to XLEN.
REQ-019 SHALL form SH as the shamt zero-extended: inst[24:20] for XLEN=32 or OP-IMM-32, inst[25:20] for OP-IMM at XLEN=64.
REQ-020 SHALL drive imm_o=0 for NONE and whenever illegal_o=1 (type then NONE).
REQ-021 SHALL register all outputs: 1-cycle latency from the accepting edge to valid_o.
REQ-022 SHALL implement ready_o = !valid_q || ready_i (combinational, no bubble at full throughput).
REQ-023 SHALL accept input on a clock edge with valid_i && ready_o, loading the result register and setting valid_q.
REQ-024 SHALL clear valid_q when ready_i && valid_q && !(valid_i && ready_o).
REQ-025 SHALL hold imm_o, imm_type_o, illegal_o and inst_o stable while valid_o && !ready_i.
REQ-026 SHALL have flush_i take priority over all: next valid_q=0, input discarded that cycle, ready_o unaffected combinationally.
REQ-027 SHALL update the data registers only on accept; no data enable on flush.
REQ-028 SHALL hold valid_o and data when valid_i=1 and ready_o=0 (stall), with no capture.

Reset
REQ-029 SHALL asynchronously clear, on rst_ni=0: valid_o=0, imm_o=0, imm_type_o=NONE, illegal_o=0, inst_o=0.
REQ-030 SHALL have reset asserted mid-transfer drop the held result; the first post-reset edge with valid_i=1 accepts (ready_o=1).

Structure
REQ-031 SHALL define imm_type_e (NONE, I, S, B, U, J, Z, SH, 3-bit) and the opcode constants in the shared core package.
REQ-032 SHALL split the combinational extractor into a sub-module imm_extract (inst, XLEN -> imm, type, illegal); the top holds the handshake register.

Verification
REQ-033 SHALL verify: XLEN=32, inst 0xFFF00093 (addi x1,x0,-1) -> next cycle valid_o=1, imm_o=0xFFFFFFFF, type I.
REQ-034 SHALL verify: 0x123450B7 (lui) -> imm_o=0x12345000 type U; XLEN=64 with 0x800000B7 -> 0xFFFFFFFF80000000.
REQ-035 SHALL verify: 0xFE000EE3 (beq, -4) -> imm_o=0xFFFFFFFC type B; 0x0080006F (jal +8) -> 0x00000008 type J; 0x3002D073 (csrrwi) -> 0x00000005 type Z.
REQ-036 SHALL verify stall: ready_i=0 with result held, new valid_i=1 -> ready_o=0, outputs unchanged 5 cycles; ready_i=1 -> new result next cycle.
REQ-037 SHALL verify flush_i=1 coincident with valid_i=1 -> next cycle valid_o=0; inst 0x00000001 -> illegal_o=1, imm_o=0, type NONE.
REQ-038 SHALL verify rst_ni low mid-stall -> outputs reset immediately, ready_o=1.
